// File: rtl/deskew_collector.sv
// Deskews staggered systolic output lanes into aligned rows and buffers them in a small FIFO.
// Sticky flags report misaligned lane valids and rows dropped on a full FIFO.
module deskew_collector #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_LANES-1:0]            lane_valid,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
    output logic                            align_err,
    output logic                            overflow,
    output logic [15:0]                     row_count
);

    localparam int unsigned ROW_W = NUM_LANES * DATA_WIDTH;
    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW    = AW + 1;

    logic [NUM_LANES-1:0] av;
    logic [ROW_W-1:0]     row;

    // Lane k waits NUM_LANES-1-k cycles so every lane of a row lines up with the last lane.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        localparam int unsigned DEPTH = NUM_LANES - 1 - k;
        if (DEPTH == 0) begin : g_direct
            assign av[k]                           = lane_valid[k];
            assign row[k*DATA_WIDTH +: DATA_WIDTH] = lane_data[k*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_delay
            logic [DEPTH-1:0]                 vld_q, vld_d;
            logic [DEPTH-1:0][DATA_WIDTH-1:0] dat_q, dat_d;

            always_comb begin
                vld_d[0] = lane_valid[k];
                dat_d[0] = lane_data[k*DATA_WIDTH +: DATA_WIDTH];
                for (int s = 1; s < int'(DEPTH); s++) begin
                    vld_d[s] = vld_q[s-1];
                    dat_d[s] = dat_q[s-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    dat_q <= '0;
                end else begin
                    vld_q <= vld_d;
                    dat_q <= dat_d;
                end
            end

            assign av[k]                           = vld_q[DEPTH-1];
            assign row[k*DATA_WIDTH +: DATA_WIDTH] = dat_q[DEPTH-1];
        end
    end

    logic [ROW_W-1:0] mem_q [FIFO_DEPTH];
    logic [ROW_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [ROW_W-1:0] out_data_q, out_data_d;
    logic             align_err_q, align_err_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      row_count_q, row_count_d;
    logic             row_push_c, pop_c, full_c, accept_c;

    // FIFO control: a full FIFO still accepts a row when the head is popped in the same cycle.
    always_comb begin
        row_push_c  = &av;
        pop_c       = out_valid_q && out_ready;
        full_c      = (count_q == CW'(FIFO_DEPTH));
        accept_c    = row_push_c && (!full_c || pop_c);

        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        row_count_d = row_count_q;

        if (accept_c) begin
            mem_d[wr_ptr_q] = row;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            row_count_d     = row_count_q + 16'd1;
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        count_d     = count_q + CW'(accept_c) - CW'(pop_c);
        out_valid_d = (count_d != '0);
        out_data_d  = mem_d[rd_ptr_d];
        align_err_d = align_err_q | ((av != '0) && !row_push_c);
        overflow_d  = overflow_q | (row_push_c && full_c && !pop_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            align_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            row_count_q <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            align_err_q <= align_err_d;
            overflow_q  <= overflow_d;
            row_count_q <= row_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign align_err = align_err_q;
    assign overflow  = overflow_q;
    assign row_count = row_count_q;

endmodule
